dmem_responder: RTL

- Responder (slave) end of the CPU data-memory interface: accepts address / write data / write strobe from the MEM stage and returns read data in the same cycle.
- Backs a word-addressed data RAM, plus a small memory-mapped I/O window:
  - free-running cycle counter;
  - transmit FIFO, drained by an external consumer through a valid/ready handshake;
  - status register.
- Sits beside the CPU at top level, replacing a bare DMEM array.

---
 rtl/dmem_responder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM plus an MMIO window with a cycle
// counter, a transmit FIFO drained by valid/ready, and a status register.
module dmem_responder #(
    parameter logic [31:0] RAM_BASE   = 32'h1001_0000,
    parameter int unsigned RAM_WORDS  = 1024,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] DMEM_address,
    input  logic [31:0] write_data,
    input  logic        DMEM_WRITE,
    output logic [31:0] read_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    localparam int unsigned IW = $clog2(RAM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0]   RAM_SPAN   = 32'(4 * RAM_WORDS);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    logic [31:0]   ram [RAM_WORDS];
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [31:0]   cycle_count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic [31:0]   ram_offset;
    logic          ram_hit;
    logic [IW-1:0] ram_index;
    logic          mmio_hit;
    logic          cycle_hit;
    logic          tx_hit;
    logic          status_hit;

    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          overflow_set;
    logic          overflow_clr;
    logic          ram_we;
    logic [31:0]   status_word;

    // Offset taken on the full address so the range check covers every bit;
    // the low two bits fall away when the word index is sliced out.
    assign ram_offset = DMEM_address - RAM_BASE;
    assign ram_hit    = (DMEM_address >= RAM_BASE) && (ram_offset < RAM_SPAN);
    assign ram_index  = ram_offset[IW+1:2];

    assign mmio_hit   = (DMEM_address[31:4] == MMIO_BASE[31:4]);
    assign cycle_hit  = mmio_hit && (DMEM_address[3:2] == 2'd0);
    assign tx_hit     = mmio_hit && (DMEM_address[3:2] == 2'd1);
    assign status_hit = mmio_hit && (DMEM_address[3:2] == 2'd2);

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);
    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_mem[rd_ptr];

    // Pop is resolved first, so a full FIFO that is draining still accepts a push.
    assign pop          = !fifo_empty && out_ready;
    assign push_req     = DMEM_WRITE && tx_hit;
    assign push         = push_req && (!fifo_full || pop);
    assign overflow_set = push_req && fifo_full && !pop;
    assign overflow_clr = DMEM_WRITE && status_hit && write_data[31];
    assign ram_we       = reset && DMEM_WRITE && ram_hit;

    always_comb begin
        status_word      = '0;
        status_word[31]  = overflow;
        status_word[9:2] = 8'(count);
        status_word[1]   = fifo_full;
        status_word[0]   = fifo_empty;
    end

    always_comb begin
        read_data = '0;
        if (ram_hit) begin
            read_data = ram[ram_index];
        end else if (cycle_hit) begin
            read_data = cycle_count;
        end else if (status_hit) begin
            read_data = status_word;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cycle_count <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
        end else begin
            if (DMEM_WRITE && cycle_hit) begin
                cycle_count <= write_data;
            end else begin
                cycle_count <= cycle_count + 32'd1;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (overflow_set) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset && push) begin
            fifo_mem[wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram[ram_index] <= write_data;
        end
    end

endmodule
